// File: rtl/fetch_unit.sv
// fetch_unit: program counter and single-outstanding instruction fetch
// over a valid/ready memory port, with redirect, stall and flush.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_n;
  logic              flush;
  logic              flush_n;
  logic              load;
  logic              drop;

  // A redirect withdraws the request in the cycle it arrives.
  assign mem_req_valid = (state == REQ) && !branch_valid;
  assign mem_req_addr  = pc;

  // Next state, next pc, flush tracking and output load/clear strobes.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    flush_n = flush;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (branch_valid) begin
          pc_n = branch_target;
        end else if (mem_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (flush || branch_valid) begin
            flush_n = 1'b0;
            if (branch_valid) begin
              pc_n = branch_target;
            end
            state_n = REQ;
          end else begin
            load    = 1'b1;
            state_n = HOLD;
          end
        end else if (branch_valid) begin
          pc_n    = branch_target;
          flush_n = 1'b1;
        end
      end
      HOLD: begin
        if (branch_valid) begin
          pc_n    = branch_target;
          drop    = 1'b1;
          state_n = REQ;
        end else if (!stall) begin
          pc_n    = pc + ADDR_W'(PC_STEP);
          drop    = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state: FSM, fetch pc and pending-flush flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      flush <= flush_n;
    end
  end

  // Presented instruction; pc_out/instruction persist after valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      pc_out      <= pc;
      instruction <= mem_rsp_data;
      instr_valid <= 1'b1;
    end else if (drop) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that generates the program counter and pulls instruction words from instruction memory over a valid/ready request and response interface.
- Presents the fetched word as `instruction` together with `pc_out`.
- These two outputs are the signals the CPU top level and its simulation monitors sample every clock.
- Supports branch redirect, consumer stall, and flushing of one in-flight fetch.

Parameters:
- ADDR_W, 32, width of the PC and the memory address.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  fetch address (equals the internal pc).
- mem_rsp_valid  in  1  response data valid.
- mem_rsp_data  in  DATA_W  fetched instruction word.
- branch_valid  in  1  redirect request, one-cycle pulse.
- branch_target  in  ADDR_W  redirect address.
- stall  in  1  consumer not ready to take the current instruction.
- pc_out  out  ADDR_W  address of the presented instruction.
- instruction  out  DATA_W  presented instruction word.
- instr_valid  out  1  pc_out and instruction are valid.

Behaviour:
- State machine has four states: IDLE, REQ, WAIT, HOLD. Only one request may be outstanding at a time.
- On reset:
  - state = IDLE, pc = RESET_PC, flush = 0.
  - pc_out = RESET_PC, instruction = 0, instr_valid = 0.
  - mem_req_valid = 0.
- IDLE: moves to REQ on the next clock unconditionally.
- Output decode (combinational from state):
  - mem_req_valid = (state == REQ) && !branch_valid.
  - mem_req_addr = pc.
- REQ:
  - If branch_valid: pc <= branch_target and stay in REQ. The request is withdrawn that cycle even if mem_req_ready is high.
  - Else if mem_req_ready: move to WAIT.
- WAIT, with mem_rsp_valid && !flush && !branch_valid:
  - instruction <= mem_rsp_data, pc_out <= pc, instr_valid <= 1.
  - Move to HOLD.
- WAIT, with branch_valid and no response this cycle:
  - pc <= branch_target, flush <= 1, stay in WAIT.
- WAIT, with mem_rsp_valid && (flush || branch_valid):
  - Discard the response; do not touch the outputs.
  - flush <= 0.
  - If branch_valid: pc <= branch_target.
  - Move to REQ.
- HOLD:
  - If branch_valid: pc <= branch_target, instr_valid <= 0, move to REQ. Branch has priority over stall.
  - Else if !stall: pc <= pc + PC_STEP, instr_valid <= 0, move to REQ.
  - Else: hold all outputs stable.
- The consumer takes an instruction on the cycle where instr_valid && !stall. Each fetched word is consumed exactly once.
- pc arithmetic is modulo 2^ADDR_W and wraps silently.
- Outputs pc_out, instruction and instr_valid are registered. Once instr_valid is deasserted, pc_out and instruction keep their last values.
- mem_rsp_valid in IDLE, REQ or HOLD is ignored.
- Throughput: with zero-wait memory (ready = 1, response one cycle after acceptance), one instruction per 3 cycles: REQ → WAIT → HOLD.
- Reset mid-operation returns the block to IDLE and abandons any outstanding fetch. Instruction memory shares this reset, so no stale response may follow.
- branch_target alignment is not checked; it is used as given.

Test Plan:
- Reset, then memory with ready = 1 and a 1-cycle response returning the address as data:
  - First mem_req_valid appears 1 cycle after reset deasserts, with addr 0x0.
  - instr_valid outputs are pc_out/instruction = 0/0x0, 4/0x4, 8/0x8, at a 3-cycle spacing.
- mem_req_ready held low for 4 cycles: mem_req_valid stays high with addr constant; no instr_valid pulse during that time.
- stall high for 5 cycles while instr_valid is high: pc_out and instruction stay constant, no new request is issued, and the next fetch address is old pc + 4.
- branch_valid with target 0x100 pulsed in WAIT, and the response 0xDEAD arrives 2 cycles later:
  - 0xDEAD is never presented.
  - The next request address is 0x100.
  - The next instr_valid shows pc_out = 0x100.
- branch_valid and mem_rsp_valid in the same WAIT cycle: the response is dropped and the next request goes to the branch target. Also, RESET_PC = 0xFFFFFFFC gives a second fetch at 0x0 (wrap-around).
- reset asserted during WAIT: the next cycle shows instr_valid = 0, mem_req_valid = 0 and pc_out = RESET_PC, and fetching restarts at RESET_PC.
